// File: rtl/stream_router_pkg.sv
// Shared types and width helpers for the stream router (1:N packet demux).
package stream_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } router_state_t;

  // One extra bit so the id can be compared against STREAM_COUNT without overflow.
  function automatic int id_cmp_width(input int id_width);
    return id_width + 1;
  endfunction

endpackage

// File: rtl/stream_router_if.sv
// Merged input stream plus the N steered output streams of the router.
interface stream_router_if #(
  parameter int STREAM_COUNT = 2,
  parameter int T_QOS__WIDTH = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID___WIDTH = 1
);

  logic [T_DATA_WIDTH-1:0]                    s_data;
  logic [T_QOS__WIDTH-1:0]                    s_qos;
  logic [T_ID___WIDTH-1:0]                    s_id;
  logic                                       s_last;
  logic                                       s_valid;
  logic                                       s_ready;

  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data;
  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos;
  logic [STREAM_COUNT-1:0]                    m_last;
  logic [STREAM_COUNT-1:0]                    m_valid;
  logic [STREAM_COUNT-1:0]                    m_ready;

  logic                                       drop;

  modport slave (
    input  s_data, s_qos, s_id, s_last, s_valid, m_ready,
    output s_ready, m_data, m_qos, m_last, m_valid, drop
  );

  modport master (
    output s_data, s_qos, s_id, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_qos, m_last, m_valid, drop
  );

endinterface

// File: rtl/stream_router_out_reg.sv
// Single-entry holding register between the merged input and the N sinks.
module stream_router_out_reg #(
  parameter int T_QOS__WIDTH = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID___WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    unload,
  input  logic [T_DATA_WIDTH-1:0] load_data,
  input  logic [T_QOS__WIDTH-1:0] load_qos,
  input  logic                    load_last,
  input  logic [T_ID___WIDTH-1:0] load_dest,
  output logic                    hold_valid,
  output logic [T_DATA_WIDTH-1:0] hold_data,
  output logic [T_QOS__WIDTH-1:0] hold_qos,
  output logic                    hold_last,
  output logic [T_ID___WIDTH-1:0] hold_dest
);

  // A load in the same cycle as an unload is a refill, so load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_qos   <= '0;
      hold_last  <= 1'b0;
      hold_dest  <= '0;
    end else if (load) begin
      hold_valid <= 1'b1;
      hold_data  <= load_data;
      hold_qos   <= load_qos;
      hold_last  <= load_last;
      hold_dest  <= load_dest;
    end else if (unload) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_router.sv
// Packet-locked 1:N stream demux with a registered output stage; packets whose
// id has no matching output are consumed and flagged on drop.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   ST_IDLE | expecting the first beat of a packet (id sampled here)
//   ST_PKT  | mid-packet, beats steered to the locked id
//   ST_DROP | mid-packet of an out-of-range id, beats discarded
module stream_router
  import stream_router_pkg::*;
#(
  parameter int STREAM_COUNT = 2,
  parameter int T_QOS__WIDTH = 4,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_ID___WIDTH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  stream_router_if.slave  bus
);

  localparam int CMP_W = id_cmp_width(T_ID___WIDTH);

  router_state_t           state_q, state_d;
  logic [T_ID___WIDTH-1:0] lock_id_q, lock_id_d;
  logic                    drop_q, drop_d;

  logic                    load;
  logic [T_ID___WIDTH-1:0] load_dest;
  logic                    hold_valid;
  logic [T_DATA_WIDTH-1:0] hold_data;
  logic [T_QOS__WIDTH-1:0] hold_qos;
  logic                    hold_last;
  logic [T_ID___WIDTH-1:0] hold_dest;

  logic [STREAM_COUNT-1:0] valid_dec;
  logic                    sel_ready;
  logic                    s_ready;
  logic                    accept;
  logic                    in_range;

  always_comb begin
    valid_dec = '0;
    for (int k = 0; k < STREAM_COUNT; k++) begin
      valid_dec[k] = hold_valid && (hold_dest == T_ID___WIDTH'(k));
    end
  end

  // Only the selected sink's ready can reach s_ready, since valid_dec is one-hot.
  assign sel_ready = |(valid_dec & bus.m_ready);
  assign s_ready   = (state_q == ST_DROP) || !hold_valid || sel_ready;
  assign accept    = bus.s_valid && s_ready;
  assign in_range  = {1'b0, bus.s_id} < CMP_W'(STREAM_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lock_id_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    drop_d    = 1'b0;
    load      = 1'b0;
    load_dest = lock_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_range) begin
            load      = 1'b1;
            load_dest = bus.s_id;
            lock_id_d = bus.s_id;
            state_d   = bus.s_last ? ST_IDLE : ST_PKT;
          end else begin
            drop_d    = 1'b1;
            state_d   = bus.s_last ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_PKT: begin
        if (accept) begin
          load = 1'b1;
          if (bus.s_last) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (accept && bus.s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  stream_router_out_reg #(
    .T_QOS__WIDTH (T_QOS__WIDTH),
    .T_DATA_WIDTH (T_DATA_WIDTH),
    .T_ID___WIDTH (T_ID___WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .unload     (sel_ready),
    .load_data  (bus.s_data),
    .load_qos   (bus.s_qos),
    .load_last  (bus.s_last),
    .load_dest  (load_dest),
    .hold_valid (hold_valid),
    .hold_data  (hold_data),
    .hold_qos   (hold_qos),
    .hold_last  (hold_last),
    .hold_dest  (hold_dest)
  );

  assign bus.s_ready = s_ready;
  assign bus.m_valid = valid_dec;
  assign bus.m_data  = {STREAM_COUNT{hold_data}};
  assign bus.m_qos   = {STREAM_COUNT{hold_qos}};
  assign bus.m_last  = {STREAM_COUNT{hold_last}};
  assign bus.drop    = drop_q;

endmodule
